dma_lite_cmd_master: RTL and testbench

// - AXI-Lite initiator that programs and monitors the DMA control register block from fabric logic.
// - Takes one transfer request (direction + target address); writes reg 0 (target address),

---
 rtl/dma_lite_pkg.sv | 46 ++++
 rtl/dma_lite_cmd_master_lite_write_txn.sv | 59 +++++
 rtl/dma_lite_cmd_master.sv | 194 +++++++++++++++++++
 tb/tb_dma_lite_cmd_master.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_lite_pkg.sv
// Shared constants, state encoding and helpers for the DMA control-register initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dma_lite_pkg;

  // Register indices on the DMA control slave
  localparam logic REG_ADDR    = 1'b0;
  localparam logic REG_CMDSTAT = 1'b1;

  // Command word bit positions
  localparam int CMD_DIR = 31;
  localparam int CMD_GO  = 30;

  // Status word bit positions
  localparam int ST_RD_BUSY = 15;
  localparam int ST_WR_BUSY = 14;

  // Transfer direction encoding
  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_CMD,
    ST_POLL_AR,
    ST_POLL_R,
    ST_GAP,
    ST_FIN
  } state_e;

  // Command register value: direction plus the go bit
  function automatic logic [31:0] cmd_word(input logic dir);
    logic [31:0] w;
    w          = '0;
    w[CMD_DIR] = dir;
    w[CMD_GO]  = 1'b1;
    return w;
  endfunction

  // Busy bit that belongs to the direction in flight
  function automatic logic watched_busy(input logic dir, input logic [31:0] status);
    return (dir == DIR_WRITE) ? status[ST_WR_BUSY] : status[ST_RD_BUSY];
  endfunction

endpackage

// File: rtl/dma_lite_cmd_master_lite_write_txn.sv
// One AXI-Lite single-beat write (AW + W, then B) held active while start_i is high.
// Latency: AW/W issued the cycle start_i is seen; done_o pulses on the B handshake.
// Backpressure: AW and W each hold until their own ready; bready only after both accepted.
module lite_write_txn (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        addr_i,
  input  logic [31:0] data_i,
  output logic        done_o,
  output logic [1:0]  resp_o,
  output logic        awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  // Address and data come straight from the caller, which keeps them stable for the whole write
  assign awaddr_o  = addr_i;
  assign wdata_o   = data_i;
  assign awvalid_o = start_i & ~aw_done_q;
  assign wvalid_o  = start_i & ~w_done_q;
  assign bready_o  = start_i & aw_done_q & w_done_q;
  assign done_o    = bvalid_i & bready_o;
  assign resp_o    = bresp_i;

  // Track which of AW/W has been accepted; clear when the write ends or is abandoned
  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (!start_i || done_o) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (awvalid_o && awready_i) aw_done_d = 1'b1;
      if (wvalid_o && wready_i)   w_done_d  = 1'b1;
    end
  end

  // Handshake flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: rtl/dma_lite_cmd_master.sv
// Programs DMA target address and command over AXI-Lite, then polls status until the busy bit clears.
// Latency: accept -> done in 8 cycles with a zero-wait slave and an idle first poll.
// Backpressure: cmd_ready only in IDLE; every AXI valid holds until its handshake.
module dma_lite_cmd_master
  import dma_lite_pkg::*;
#(
  parameter int unsigned POLL_GAP = 16,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic        m_axi_lite_aclk,
  input  logic        axi_resetnn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [31:0] cmd_addr,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [15:0] last_status,
  output logic        m_axi_lite_awaddr,
  output logic        m_axi_lite_awvalid,
  input  logic        m_axi_lite_awready,
  output logic [31:0] m_axi_lite_wdata,
  output logic        m_axi_lite_wvalid,
  input  logic        m_axi_lite_wready,
  input  logic [1:0]  m_axi_lite_bresp,
  input  logic        m_axi_lite_bvalid,
  output logic        m_axi_lite_bready,
  output logic        m_axi_lite_araddr,
  output logic        m_axi_lite_arvalid,
  input  logic        m_axi_lite_arready,
  input  logic [31:0] m_axi_lite_rdata,
  input  logic        m_axi_lite_rvalid,
  output logic        m_axi_lite_rready
);

  // GAP lasts at least one cycle, so POLL_GAP=0 behaves like a single-cycle gap
  localparam logic [31:0] GAP_LAST = (POLL_GAP == 0) ? 32'd0 : 32'(POLL_GAP - 1);
  localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
  localparam bit          TMO_EN   = (TIMEOUT != 0);

  state_e      state_q, state_d;
  logic        dir_q, dir_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [15:0] last_status_q, last_status_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  logic        wr_start;
  logic        wr_idx;
  logic [31:0] wr_data;
  logic        wr_done;
  logic [1:0]  wr_resp;
  logic        timeout_hit;

  // Both register writes share one write engine; the state selects which register and payload
  assign wr_start = (state_q == ST_WR_ADDR) || (state_q == ST_WR_CMD);
  assign wr_idx   = (state_q == ST_WR_CMD) ? REG_CMDSTAT : REG_ADDR;
  assign wr_data  = (state_q == ST_WR_CMD) ? cmd_word(dir_q) : addr_q;

  lite_write_txn u_wr (
    .clk_i     (m_axi_lite_aclk),
    .rst_ni    (axi_resetnn),
    .start_i   (wr_start),
    .addr_i    (wr_idx),
    .data_i    (wr_data),
    .done_o    (wr_done),
    .resp_o    (wr_resp),
    .awaddr_o  (m_axi_lite_awaddr),
    .awvalid_o (m_axi_lite_awvalid),
    .awready_i (m_axi_lite_awready),
    .wdata_o   (m_axi_lite_wdata),
    .wvalid_o  (m_axi_lite_wvalid),
    .wready_i  (m_axi_lite_wready),
    .bresp_i   (m_axi_lite_bresp),
    .bvalid_i  (m_axi_lite_bvalid),
    .bready_o  (m_axi_lite_bready)
  );

  assign timeout_hit = TMO_EN && (tmo_cnt_q >= TMO_LAST);

  assign cmd_ready          = (state_q == ST_IDLE);
  assign busy               = (state_q != ST_IDLE);
  assign done               = (state_q == ST_FIN);
  assign err                = (state_q == ST_FIN) && err_q;
  assign last_status        = last_status_q;
  assign m_axi_lite_araddr  = REG_CMDSTAT;
  assign m_axi_lite_arvalid = (state_q == ST_POLL_AR);
  assign m_axi_lite_rready  = (state_q == ST_POLL_R);

  // Sequencer: next state, latched command, poll gap and timeout counters
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    addr_d        = addr_q;
    err_d         = err_q;
    last_status_d = last_status_q;
    gap_cnt_d     = gap_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          addr_d  = cmd_addr;
          err_d   = 1'b0;
          state_d = ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: begin
        if (wr_done) begin
          if (wr_resp != 2'b00) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else begin
            state_d = ST_WR_CMD;
          end
        end
      end
      ST_WR_CMD: begin
        if (wr_done) begin
          if (wr_resp != 2'b00) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else begin
            tmo_cnt_d = '0;
            state_d   = ST_POLL_AR;
          end
        end
      end
      ST_POLL_AR: begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        // An AR accepted this cycle wins over the timeout so no read is left dangling
        if (m_axi_lite_arready) begin
          state_d = ST_POLL_R;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_POLL_R: begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        if (m_axi_lite_rvalid) begin
          last_status_d = m_axi_lite_rdata[15:0];
          if (watched_busy(dir_q, m_axi_lite_rdata)) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_GAP: begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (gap_cnt_q >= GAP_LAST) begin
          state_d = ST_POLL_AR;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge m_axi_lite_aclk or negedge axi_resetnn) begin
    if (!axi_resetnn) begin
      state_q       <= ST_IDLE;
      dir_q         <= DIR_READ;
      addr_q        <= '0;
      err_q         <= 1'b0;
      last_status_q <= '0;
      gap_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      addr_q        <= addr_d;
      err_q         <= err_d;
      last_status_q <= last_status_d;
      gap_cnt_q     <= gap_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_dma_lite_cmd_master.sv
// Bench for dma_lite_cmd_master: behavioural AXI-Lite slave plus scoreboard on writes and completions.
// Latency: n/a.
// Backpressure: slave stalls AW/W by configurable cycle counts.
module tb_dma_lite_cmd_master;

  localparam int GAP = 4;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic        done, err, busy;
  logic [15:0] last_status;
  logic        m_axi_lite_awaddr, m_axi_lite_awvalid;
  logic        m_axi_lite_awready = 1'b0;
  logic [31:0] m_axi_lite_wdata;
  logic        m_axi_lite_wvalid;
  logic        m_axi_lite_wready = 1'b0;
  logic [1:0]  m_axi_lite_bresp = 2'b00;
  logic        m_axi_lite_bvalid = 1'b0;
  logic        m_axi_lite_bready;
  logic        m_axi_lite_araddr, m_axi_lite_arvalid;
  logic        m_axi_lite_arready = 1'b0;
  logic [31:0] m_axi_lite_rdata = '0;
  logic        m_axi_lite_rvalid = 1'b0;
  logic        m_axi_lite_rready;

  always #5 clk = ~clk;

  dma_lite_cmd_master #(.POLL_GAP(GAP), .TIMEOUT(TMO)) dut (
    .m_axi_lite_aclk    (clk),
    .axi_resetnn        (rst_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_dir            (cmd_dir),
    .cmd_addr           (cmd_addr),
    .done               (done),
    .err                (err),
    .busy               (busy),
    .last_status        (last_status),
    .m_axi_lite_awaddr  (m_axi_lite_awaddr),
    .m_axi_lite_awvalid (m_axi_lite_awvalid),
    .m_axi_lite_awready (m_axi_lite_awready),
    .m_axi_lite_wdata   (m_axi_lite_wdata),
    .m_axi_lite_wvalid  (m_axi_lite_wvalid),
    .m_axi_lite_wready  (m_axi_lite_wready),
    .m_axi_lite_bresp   (m_axi_lite_bresp),
    .m_axi_lite_bvalid  (m_axi_lite_bvalid),
    .m_axi_lite_bready  (m_axi_lite_bready),
    .m_axi_lite_araddr  (m_axi_lite_araddr),
    .m_axi_lite_arvalid (m_axi_lite_arvalid),
    .m_axi_lite_arready (m_axi_lite_arready),
    .m_axi_lite_rdata   (m_axi_lite_rdata),
    .m_axi_lite_rvalid  (m_axi_lite_rvalid),
    .m_axi_lite_rready  (m_axi_lite_rready)
  );

  typedef struct { logic aidx; logic [31:0] data; } wr_t;
  typedef struct { logic err; logic [15:0] st; int n_aw; int n_ar; } done_t;

  int n_cmp = 0;
  int n_fail = 0;

  wr_t   exp_wr[$];
  done_t exp_done[$];

  // slave configuration (written by stimulus)
  int          aw_dly = 0, w_dly = 0;
  logic [1:0]  bresp_cfg[$];
  logic [31:0] stat_q[$];
  logic [31:0] stat_default = '0;
  bit          hold_r = 1'b0;
  bit          rand_stat = 1'b0;
  int          base_aw = 0, base_ar = 0, base_viol = 0;
  logic [15:0] model_status = '0;

  // slave state (written by slave loop)
  int          aw_wait = 0, w_wait = 0, aw_hi = 0, w_hi = 0;
  bit          aw_seen = 0, w_seen = 0, b_hs = 0, r_hs = 0, ar_acc = 0;
  bit          aw_pend = 0, w_pend = 0, ar_pend = 0;
  logic        cap_aidx = 1'b0, prev_aidx = 1'b0;
  logic [31:0] cap_wdata = '0, prev_wdata = '0;
  int          cyc = 0, last_r_cyc = 0, n_aw = 0, n_ar = 0, viol = 0;
  int          aw_hi_log[$], w_hi_log[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  // Slave and monitor: acts on each falling edge, handshakes complete on the following rising edge
  initial begin : slave
    done_t e;
    wr_t   w;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_axi_lite_awready = 0; m_axi_lite_wready = 0; m_axi_lite_bvalid = 0;
        m_axi_lite_arready = 0; m_axi_lite_rvalid = 0;
        aw_seen = 0; w_seen = 0; b_hs = 0; r_hs = 0; ar_acc = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; aw_hi = 0; w_hi = 0;
      end else begin
        // completion scoreboard
        if (done) begin
          if (exp_done.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_done: got done=1, expected no pending command");
          end else begin
            e = exp_done.pop_front();
            check("done_err", {31'b0, err}, {31'b0, e.err});
            check("last_status", {16'b0, last_status}, {16'b0, e.st});
            check("aw_count", n_aw - base_aw, e.n_aw);
            if (e.n_ar >= 0) check("ar_count", n_ar - base_ar, e.n_ar);
            check("protocol_viol", viol - base_viol, 0);
          end
        end
        // master-side rules: valid holds until ready, payload stable
        if (aw_pend && (!m_axi_lite_awvalid || m_axi_lite_awaddr !== prev_aidx)) viol++;
        if (w_pend && (!m_axi_lite_wvalid || m_axi_lite_wdata !== prev_wdata)) viol++;
        if (ar_pend && !m_axi_lite_arvalid) viol++;
        // B channel: respond the cycle after both AW and W were accepted
        if (b_hs) begin
          m_axi_lite_bvalid = 0; b_hs = 0; aw_seen = 0; w_seen = 0;
        end else if (aw_seen && w_seen && !m_axi_lite_bvalid) begin
          m_axi_lite_bvalid = 1;
          m_axi_lite_bresp = (bresp_cfg.size() != 0) ? bresp_cfg.pop_front() : 2'b00;
          if (exp_wr.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_write: got idx %0d data 0x%0h, expected none", cap_aidx, cap_wdata);
          end else begin
            w = exp_wr.pop_front();
            check("wr_idx", {31'b0, cap_aidx}, {31'b0, w.aidx});
            check("wr_data", cap_wdata, w.data);
          end
          aw_hi_log.push_back(aw_hi); w_hi_log.push_back(w_hi);
          aw_hi = 0; w_hi = 0;
        end
        if (m_axi_lite_bready && !(aw_seen && w_seen)) viol++;
        if (m_axi_lite_bvalid && m_axi_lite_bready) b_hs = 1;
        // AW channel
        m_axi_lite_awready = 0;
        if (m_axi_lite_awvalid && !aw_seen) begin
          if (aw_hi == 0) aw_wait = aw_dly;
          aw_hi++;
          if (aw_wait > 0) aw_wait--;
          else begin m_axi_lite_awready = 1; aw_seen = 1; n_aw++; cap_aidx = m_axi_lite_awaddr; end
        end
        aw_pend = m_axi_lite_awvalid && !m_axi_lite_awready;
        prev_aidx = m_axi_lite_awaddr;
        // W channel
        m_axi_lite_wready = 0;
        if (m_axi_lite_wvalid && !w_seen) begin
          if (w_hi == 0) w_wait = w_dly;
          w_hi++;
          if (w_wait > 0) w_wait--;
          else begin m_axi_lite_wready = 1; w_seen = 1; cap_wdata = m_axi_lite_wdata; end
        end
        w_pend = m_axi_lite_wvalid && !m_axi_lite_wready;
        prev_wdata = m_axi_lite_wdata;
        // R channel: data the cycle after AR acceptance
        if (r_hs) begin m_axi_lite_rvalid = 0; r_hs = 0; end
        if (ar_acc && !hold_r) begin
          m_axi_lite_rvalid = 1;
          m_axi_lite_rdata = (stat_q.size() != 0) ? stat_q.pop_front() : stat_default;
          ar_acc = 0;
        end
        if (m_axi_lite_rvalid && m_axi_lite_rready) begin r_hs = 1; last_r_cyc = cyc; end
        // AR channel: zero-wait, with spacing check against the previous R beat
        m_axi_lite_arready = 0;
        if (m_axi_lite_arvalid && !ar_acc && !m_axi_lite_rvalid) begin
          if (m_axi_lite_araddr !== 1'b1) viol++;
          if ((n_ar - base_ar) > 0 && (cyc - last_r_cyc - 1) < GAP) viol++;
          m_axi_lite_arready = 1; ar_acc = 1; n_ar++;
        end
        ar_pend = m_axi_lite_arvalid && !m_axi_lite_arready;
      end
    end
  end

  // Reference model: expected register writes and completion for one command
  task automatic prep(input logic dir, input logic [31:0] addr, input int awd, input int wd,
                      input logic [1:0] br0, input logic [1:0] br1, input int nbusy, input bit stuck);
    done_t e;
    logic [31:0] s;
    int wbit;
    wbit = dir ? 14 : 15;
    bresp_cfg.delete(); stat_q.delete();
    bresp_cfg.push_back(br0); bresp_cfg.push_back(br1);
    aw_dly = awd; w_dly = wd; stat_default = '0;
    exp_wr.push_back('{1'b0, addr});
    e.err = 1'b0; e.st = model_status; e.n_aw = 1; e.n_ar = 0;
    if (br0 != 2'b00) e.err = 1'b1;
    else begin
      exp_wr.push_back('{1'b1, {dir, 1'b1, 30'b0}});
      e.n_aw = 2;
      if (br1 != 2'b00) e.err = 1'b1;
      else if (stuck) begin
        stat_default = 32'h1 << wbit;
        e.err = 1'b1; e.st = stat_default[15:0]; e.n_ar = -1;
      end else begin
        for (int i = 0; i < nbusy; i++) begin
          s = rand_stat ? $urandom : 32'h0;
          s[wbit] = 1'b1;
          stat_q.push_back(s);
        end
        s = rand_stat ? $urandom : 32'h0;
        s[wbit] = 1'b0;
        stat_q.push_back(s);
        e.n_ar = nbusy + 1; e.st = s[15:0];
      end
    end
    model_status = e.st;
    exp_done.push_back(e);
  endtask

  // Present the command; returns on the falling edge where it is accepted
  task automatic issue(input logic dir, input logic [31:0] addr);
    int k;
    @(negedge clk);
    cmd_valid = 1; cmd_dir = dir; cmd_addr = addr;
    k = 0;
    while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
    check("cmd_ready_accept", {31'b0, cmd_ready}, 32'd1);
    base_aw = n_aw; base_ar = n_ar; base_viol = viol;
  endtask

  task automatic wait_done(input int exp_lat);
    int k;
    for (k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = 0; cmd_addr = $urandom; cmd_dir = $urandom;
        check("busy_active", {31'b0, busy}, 32'd1);
      end
      if (done) break;
    end
    if (k > 600) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no done in 600 cycles, expected done");
      exp_done.delete(); exp_wr.delete();
    end else if (exp_lat > 0) begin
      check("latency", k, exp_lat);
    end
  endtask

  task automatic run_cmd(input logic dir, input logic [31:0] addr, input int awd, input int wd,
                         input logic [1:0] br0, input logic [1:0] br1, input int nbusy,
                         input bit stuck, input int exp_lat);
    prep(dir, addr, awd, wd, br0, br1, nbusy, stuck);
    issue(dir, addr);
    wait_done(exp_lat);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valids"}, {27'b0, m_axi_lite_awvalid, m_axi_lite_wvalid, m_axi_lite_bready,
                             m_axi_lite_arvalid, m_axi_lite_rready}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_last_status"}, {16'b0, last_status}, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1;

    // WRITE, zero-wait slave, idle first poll: done on the 8th cycle counting the accept cycle
    rand_stat = 0;
    run_cmd(1'b1, 32'h1000_0040, 0, 0, 2'b00, 2'b00, 0, 0, 7);

    // READ, busy three times then idle; spacing checked by the slave
    run_cmd(1'b0, 32'h2000_1234, 0, 0, 2'b00, 2'b00, 3, 0, 0);

    // awready stalled 5 cycles, wready immediate
    aw_hi_log.delete(); w_hi_log.delete();
    run_cmd(1'b1, 32'h3000_0000, 5, 0, 2'b00, 2'b00, 0, 0, 0);
    check("aw_valid_cycles", (aw_hi_log.size() != 0) ? aw_hi_log[0] : -1, 6);
    check("w_valid_cycles", (w_hi_log.size() != 0) ? w_hi_log[0] : -1, 1);

    // SLVERR on the address write: no command write, no polling
    run_cmd(1'b1, 32'h4000_0008, 1, 2, 2'b10, 2'b00, 0, 0, 0);

    // Status stuck busy on a WRITE: timeout with error
    run_cmd(1'b1, 32'h5000_0000, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    @(negedge clk);
    check("cmd_ready_after_timeout", {31'b0, cmd_ready}, 32'd1);

    // Reset asserted while waiting for the R beat
    prep(1'b0, 32'h6000_0000, 0, 0, 2'b00, 2'b00, 0, 0);
    hold_r = 1;
    issue(1'b0, 32'h6000_0000);
    k = 0;
    do begin
      @(negedge clk);
      if (k == 0) cmd_valid = 0;
      k++;
    end while (!m_axi_lite_rready && k < 50);
    check("reached_poll_r", {31'b0, m_axi_lite_rready}, 32'd1);
    #1 rst_n = 0;
    #1 check_idle_outputs("midreset");
    exp_done.delete(); exp_wr.delete(); model_status = '0;
    repeat (2) @(negedge clk);
    hold_r = 0;
    rst_n = 1;
    rand_stat = 1;
    run_cmd(1'b0, 32'h7000_0010, 0, 1, 2'b00, 2'b00, 1, 0, 0);

    // Randomized commands
    for (int i = 0; i < 25; i++) begin
      logic [1:0] b0, b1;
      b0 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b1 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              b0, b1, $urandom_range(0, 2), 0, 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_done.size() + exp_wr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
